// File: rtl/seq_datapath_pkg.sv
// -----------------------------------------------------------------------------
// seq_datapath_pkg
//   Shared types for the sequenced bus datapath: ALU operation codes, the
//   T-state sequencer states and the opcode width.
// -----------------------------------------------------------------------------
package seq_datapath_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD         = 4'd0,
    OP_SUB         = 4'd1,
    OP_AND         = 4'd2,
    OP_OR          = 4'd3,
    OP_XOR         = 4'd4,
    OP_SHL         = 4'd5,
    OP_SHR         = 4'd6,
    OP_SRA         = 4'd7,
    OP_MUL         = 4'd8,
    OP_ILLEGAL_MIN = 4'd9
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

endpackage

// File: rtl/seq_datapath_if.sv
// -----------------------------------------------------------------------------
// seq_datapath_if
//   Control/status bundle for seq_datapath.
//   master : drives start/op/ra/rb/rd and the GPR load port; sees status.
//   slave  : the datapath side.
//   start, op, ra, rb, rd      operation request (start sampled only in IDLE)
//   ld_en, ld_addr, ld_data    GPR load port (honoured only in IDLE)
//   busy, done, err            sequencer status (done/err are 1-cycle pulses)
//   result, hi_out, lo_out     Zlow, HI and LO registers
// -----------------------------------------------------------------------------
interface seq_datapath_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
);
  localparam int REG_AW = $clog2(NUM_REGS);

  logic              start;
  logic [3:0]        op;
  logic [REG_AW-1:0] ra;
  logic [REG_AW-1:0] rb;
  logic [REG_AW-1:0] rd;
  logic              ld_en;
  logic [REG_AW-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] hi_out;
  logic [DATA_W-1:0] lo_out;

  modport master (
    output start, op, ra, rb, rd, ld_en, ld_addr, ld_data,
    input  busy, done, err, result, hi_out, lo_out
  );

  modport slave (
    input  start, op, ra, rb, rd, ld_en, ld_addr, ld_data,
    output busy, done, err, result, hi_out, lo_out
  );

endinterface

// File: rtl/seq_datapath_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Combinational ALU for seq_datapath.
//   a, b    : operands (DATA_W)
//   op      : operation code (seq_datapath_pkg::op_t values)
//   res     : 2*DATA_W result; upper half is zero except for MUL
//   illegal : op is outside OP_ADD..OP_MUL (res is then zero)
// -----------------------------------------------------------------------------
module seq_alu
  import seq_datapath_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [OP_W-1:0]     op,
  output logic [2*DATA_W-1:0] res,
  output logic                illegal
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]     sh;
  logic [DATA_W-1:0]   lo;
  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;

  assign sh    = b[SH_W-1:0];
  assign a_ext = {{DATA_W{1'b0}}, a};
  assign b_ext = {{DATA_W{1'b0}}, b};

  always_comb begin
    lo      = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  lo = a + b;
      OP_SUB:  lo = a - b;
      OP_AND:  lo = a & b;
      OP_OR:   lo = a | b;
      OP_XOR:  lo = a ^ b;
      OP_SHL:  lo = a << sh;
      OP_SHR:  lo = a >> sh;
      OP_SRA:  lo = $unsigned($signed(a) >>> sh);
      OP_MUL:  lo = '0;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    res = '0;
    if (op == OP_MUL) begin
      res = a_ext * b_ext;
    end else if (!illegal) begin
      res = {{DATA_W{1'b0}}, lo};
    end
  end

endmodule

// File: rtl/seq_datapath.sv
// -----------------------------------------------------------------------------
// seq_datapath
//   Single-bus datapath (GPR file, Y, 2W-bit Z, HI/LO) with a built-in
//   T-state sequencer: Rd <= Ra op Rb, or HI:LO <= Ra*Rb for MUL.
//   clk : rising-edge clock
//   clr : asynchronous active-high reset
//   dp  : seq_datapath_if.slave (request, GPR load port, status, registers)
//   Optional: define SEQ_DATAPATH_ZERO_REG_EN to make R0 a hardwired zero
//   (reads 0, load-port and write-back writes to R0 discarded).
// -----------------------------------------------------------------------------
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic           clk,
  input  logic           clr,
  seq_datapath_if.slave  dp
);

  localparam int REG_AW = $clog2(NUM_REGS);

  state_t              state_q;
  logic [OP_W-1:0]     op_q;
  logic [REG_AW-1:0]   ra_q;
  logic [REG_AW-1:0]   rb_q;
  logic [REG_AW-1:0]   rd_q;
  logic                err_q;
  logic [DATA_W-1:0]   y_q;
  logic [2*DATA_W-1:0] z_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [DATA_W-1:0]   gpr [NUM_REGS];

  logic [REG_AW-1:0]   rd_sel;
  logic [DATA_W-1:0]   gpr_val;
  logic [DATA_W-1:0]   bus_val;
  logic [2*DATA_W-1:0] alu_res;
  logic                alu_ill;
  logic                ld_ok;
  logic                wb_ok;

  // Single read port onto the bus: Ra in T1, Rb in T2, Zlow in T3.
  always_comb begin
    rd_sel = ra_q;
    if (state_q == S_T2) begin
      rd_sel = rb_q;
    end
    gpr_val = gpr[rd_sel];
`ifdef SEQ_DATAPATH_ZERO_REG_EN
    if (rd_sel == '0) begin
      gpr_val = '0;
    end
`endif
    case (state_q)
      S_T1, S_T2: bus_val = gpr_val;
      S_T3:       bus_val = z_q[DATA_W-1:0];
      default:    bus_val = '0;
    endcase
  end

  always_comb begin
    ld_ok = 1'b1;
    wb_ok = 1'b1;
`ifdef SEQ_DATAPATH_ZERO_REG_EN
    ld_ok = (dp.ld_addr != '0);
    wb_ok = (rd_q != '0);
`endif
  end

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .a       (y_q),
    .b       (bus_val),
    .op      (op_q),
    .res     (alu_res),
    .illegal (alu_ill)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      y_q     <= '0;
      z_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        gpr[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // Load lands at the accepting edge, so T1 sees the new value.
          if (dp.ld_en && ld_ok) begin
            gpr[dp.ld_addr] <= dp.ld_data;
          end
          if (dp.start) begin
            op_q    <= dp.op;
            ra_q    <= dp.ra;
            rb_q    <= dp.rb;
            rd_q    <= dp.rd;
            state_q <= S_T1;
          end
        end
        S_T1: begin
          y_q     <= bus_val;
          state_q <= S_T2;
        end
        S_T2: begin
          z_q     <= alu_res;
          err_q   <= alu_ill;
          state_q <= alu_ill ? S_FIN : S_T3;
        end
        S_T3: begin
          if (op_q == OP_MUL) begin
            lo_q    <= z_q[DATA_W-1:0];
            state_q <= S_T4;
          end else begin
            if (wb_ok) begin
              gpr[rd_q] <= bus_val;
            end
            state_q <= S_FIN;
          end
        end
        S_T4: begin
          hi_q    <= z_q[2*DATA_W-1:DATA_W];
          state_q <= S_FIN;
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dp.busy   = (state_q != S_IDLE);
  assign dp.done   = (state_q == S_FIN) && !err_q;
  assign dp.err    = (state_q == S_FIN) && err_q;
  assign dp.result = z_q[DATA_W-1:0];
  assign dp.hi_out = hi_q;
  assign dp.lo_out = lo_q;

endmodule

// File: doc/seq_datapath.md
Name: seq_datapath

Overview:
- Parametrised successor to the Phase 1 bus datapath: GPR file, Y operand register, 2W-bit Z register, HI/LO pair and a single internal bus, with a built-in T-state sequencer.
- Register-register ALU instructions (Rd <= Ra op Rb, or HI:LO <= Ra*Rb) run from a start/done handshake, so external control-signal drive is not required.
- Sits between the future control unit and memory/IO; a separate load port initialises GPRs.

Parameters:
- DATA_W, 32, datapath width in bits (power of two, >= 8).
- NUM_REGS, 16, number of GPRs (power of two, >= 2).
- REG_AW, $clog2(NUM_REGS), GPR address width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  asynchronous active-high reset.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  4  operation code.
- ra  in  REG_AW  source A register.
- rb  in  REG_AW  source B register.
- rd  in  REG_AW  destination register.
- ld_en  in  1  GPR load strobe; honoured only in IDLE.
- ld_addr  in  REG_AW  GPR to load.
- ld_data  in  DATA_W  load value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on an illegal op.
- result  out  DATA_W  current Zlow register.
- hi_out  out  DATA_W  HI register.
- lo_out  out  DATA_W  LO register.

Behaviour:
- Reset (clr=1, asynchronous): all GPRs, Y, Z, HI and LO are 0; state is IDLE; busy, done and err are 0.
- Reset mid-operation aborts immediately. No done or err is produced, and no partial write survives.
- States: IDLE, T1, T2, T3, T4, FIN.
- IDLE, start=1: latch op, ra, rb and rd into internal registers, then go to T1. Port changes after acceptance have no effect.
- T1: bus = R[ra]; Y <= bus; go to T2.
- T2: bus = R[rb]; Z <= ALU(Y, bus), full 2*DATA_W result.
  - Legal op: go to T3.
  - Illegal op: go to FIN with err flagged.
- T3:
  - Non-MUL: bus = Zlow; R[rd] <= bus; go to FIN.
  - MUL: LO <= Zlow; go to T4.
- T4 (MUL only): HI <= Zhigh; go to FIN.
- FIN: done=1 (legal op) or err=1 (illegal op) for exactly this cycle, then go to IDLE.
- Latency:
  - Start accepted at edge k.
  - Non-MUL: done high in the cycle after edge k+3.
  - MUL: done high in the cycle after edge k+4.
  - Illegal op: err high in the cycle after edge k+2.
- start asserted while busy is ignored and not queued. start held high in FIN is seen in the following IDLE cycle.
- ld_en in IDLE: R[ld_addr] <= ld_data at the clock edge. ld_en while busy is ignored.
- ld_en and start in the same IDLE cycle: both are accepted. T1 reads the newly loaded value.
- ra, rb and rd may be equal. rd == ra is legal; the write occurs in T3 after both reads.
- ALU ops (Zhigh = 0 unless stated):
  - 0 ADD, 1 SUB: modulo 2^DATA_W, carry/borrow discarded.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR (logical), 7 SRA (arithmetic): shift amount is B[$clog2(DATA_W)-1:0].
  - 8 MUL: unsigned, full 2*DATA_W product.
  - 9..15: illegal; no GPR, HI or LO write.

Optional Feature:
- Macro SEQ_DATAPATH_ZERO_REG_EN.
- Defined: R0 always reads 0; writes to R0 (load port or T3) are discarded; done still pulses.
- Undefined: R0 is an ordinary GPR.

Decomposition:
- Shared package seq_datapath_pkg holds:
  - op enum: OP_ADD .. OP_MUL, OP_ILLEGAL_MIN = 9;
  - state enum: S_IDLE, S_T1, S_T2, S_T3, S_T4, S_FIN.
- One natural sub-module: seq_alu, combinational, parametrised by DATA_W. Inputs a, b, op; outputs a 2*DATA_W result and an illegal flag.
- GPR file, Y, Z, HI/LO and the FSM stay in seq_datapath.

Test Plan:
- Load R1=0x0000_0005, R2=0x0000_0003; start ADD ra=1 rb=2 rd=3 -> done in the 4th cycle after acceptance; R3 = result = 0x0000_0008; busy high for exactly 4 cycles.
- SUB R3=R2-R1 with R1=5, R2=3 -> result = 0xFFFF_FFFE; then SRA of 0x8000_0000 by 4 -> 0xF800_0000; SHR of the same by 4 -> 0x0800_0000.
- MUL R1=0xFFFF_FFFF, R2=0x0000_0002 -> hi_out = 0x0000_0001, lo_out = 0xFFFF_FFFE; done one cycle later than ADD; no GPR changes.
- op=12 -> err pulses one cycle, done stays 0; all GPR/HI/LO values unchanged. Second start while busy is ignored; ld_en while busy is ignored.
- Assert clr in T2 of an ADD -> outputs 0 and busy 0 asynchronously; no done; next start completes normally.
- With SEQ_DATAPATH_ZERO_REG_EN: load R0=0x1234, then ADD rd=0 -> R0 still reads 0; ADD ra=0 rb=1 returns R1.
